// File: rtl/coe_loader.sv
// Double-buffered 3x3 convolution kernel loader: a 9-byte config packet fills a
// shadow bank, which is copied to the active bank only between frames.
module coe_loader #(
  parameter bit RST_IDENTITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        cfg_axi_data,
  input  logic              cfg_axi_valid,
  input  logic              cfg_axi_last,
  output logic              cfg_axi_ready,
  input  logic              pix_hs,
  input  logic              out_last_hs,
  output logic              stall_in,
  output logic signed [7:0] coe_00,
  output logic signed [7:0] coe_01,
  output logic signed [7:0] coe_02,
  output logic signed [7:0] coe_10,
  output logic signed [7:0] coe_11,
  output logic signed [7:0] coe_12,
  output logic signed [7:0] coe_20,
  output logic signed [7:0] coe_21,
  output logic signed [7:0] coe_22,
  output logic              cfg_pending,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_DRAIN = 2'd1,
    S_PEND  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic       r_frame_busy;
  logic       r_cfg_err;
  logic       w_err;
  logic       w_accept;
  logic       w_shadow_wr;
  logic       w_shadow_clr;
  logic       w_swap;
  logic [7:0] w_active [9];

  assign cfg_axi_ready = (r_state != S_PEND);
  assign cfg_pending   = (r_state == S_PEND);
  assign stall_in      = (r_state == S_PEND);
  assign cfg_err       = r_cfg_err;
  assign w_accept      = cfg_axi_valid & cfg_axi_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_LOAD;
      r_cnt        <= 4'd0;
      r_frame_busy <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_frame_busy <= (r_frame_busy & ~out_last_hs) | pix_hs;
      r_cfg_err    <= w_err;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_err        = 1'b0;
    w_shadow_wr  = 1'b0;
    w_shadow_clr = 1'b0;
    w_swap       = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (w_accept) begin
          if (cfg_axi_last) begin
            w_cnt_next = 4'd0;
            if (r_cnt == 4'd8) begin
              w_shadow_wr  = 1'b1;
              w_state_next = S_PEND;
            end else begin
              // Short packet: drop the partial kernel and wait for a fresh one.
              w_err        = 1'b1;
              w_shadow_clr = 1'b1;
            end
          end else if (r_cnt == 4'd8) begin
            w_err        = 1'b1;
            w_cnt_next   = 4'd0;
            w_state_next = S_DRAIN;
          end else begin
            w_shadow_wr = 1'b1;
            w_cnt_next  = r_cnt + 4'd1;
          end
        end
      end
      S_DRAIN: begin
        if (w_accept && cfg_axi_last) begin
          w_cnt_next   = 4'd0;
          w_state_next = S_LOAD;
        end
      end
      S_PEND: begin
        // A pixel accepted this cycle starts a frame, so it also blocks the swap.
        if (!r_frame_busy && !pix_hs) begin
          w_swap       = 1'b1;
          w_state_next = S_LOAD;
        end
      end
      default: begin
        w_state_next = S_LOAD;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_bank
      logic [7:0] r_shadow;
      logic [7:0] r_active;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_shadow <= 8'd0;
          r_active <= ((gi == 4) && RST_IDENTITY) ? 8'd1 : 8'd0;
        end else begin
          if (w_shadow_clr)
            r_shadow <= 8'd0;
          else if (w_shadow_wr && (r_cnt == 4'(gi)))
            r_shadow <= cfg_axi_data;
          if (w_swap)
            r_active <= r_shadow;
        end
      end

      assign w_active[gi] = r_active;
    end
  endgenerate

  assign coe_00 = w_active[0];
  assign coe_01 = w_active[1];
  assign coe_02 = w_active[2];
  assign coe_10 = w_active[3];
  assign coe_11 = w_active[4];
  assign coe_12 = w_active[5];
  assign coe_20 = w_active[6];
  assign coe_21 = w_active[7];
  assign coe_22 = w_active[8];

endmodule
